// File: rtl/dcm_rate_decoder_pkg.sv
// Shared constants and helpers for the divided-clock rate decoder.
// half_len() is also used by the generator side so both ends agree.
package dcm_rate_decoder_pkg;

  localparam int NUM_PROGS = 8;
  localparam int PROG_W    = 3;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } dcm_state_t;

  function automatic logic [31:0] half_len(input int half_count, input logic [PROG_W-1:0] k);
    return 32'(half_count) << k;
  endfunction

endpackage

// File: rtl/dcm_rate_decoder_sync_edge_detect.sv
// Two-flop synchroniser for the measured clock, a delay flop, and a
// registered flag that is high for one cycle after every level change.
module dcm_rate_decoder_sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic edge_flag
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;
  logic edge_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      edge_reg <= s2_reg ^ s3_reg;
    end
  end

  assign edge_flag = edge_reg;

endmodule

// File: rtl/dcm_rate_decoder.sv
// Measures each half-period of a divided clock and decodes the program
// that produced it; reports lock, rate change, malformed periods and stall.
module dcm_rate_decoder
  import dcm_rate_decoder_pkg::*;
#(
  parameter int HALF_COUNT  = 2,
  parameter int MATCH_COUNT = 2,
  parameter int TIMEOUT     = 2 * (HALF_COUNT << 7)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              din,
  output logic [PROG_W-1:0] prog_out,
  output logic              locked,
  output logic              changed,
  output logic              err,
  output logic              stalled
);

  localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);
  localparam logic [31:0] MATCH_L   = 32'(MATCH_COUNT);

  logic edge_flag;

  dcm_rate_decoder_sync_edge_detect u_sync (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .edge_flag (edge_flag)
  );

  dcm_state_t        state_reg, state_next;
  logic [31:0]       cnt_reg, cnt_next;
  logic [31:0]       match_reg, match_next;
  logic [PROG_W-1:0] cand_reg, cand_next;
  logic [PROG_W-1:0] prog_reg, prog_next;
  logic              locked_reg, locked_next;
  logic              changed_reg, changed_next;
  logic              err_reg, err_next;
  logic              stalled_reg, stalled_next;

  logic [31:0]          len;
  logic [31:0]          match_inc;
  logic [NUM_PROGS-1:0] hit;
  logic                 valid;
  logic [PROG_W-1:0]    k;

  // len is the half-period length as it would stand if an edge is seen this cycle.
  assign len       = (cnt_reg >= TIMEOUT_L) ? TIMEOUT_L : cnt_reg + 32'd1;
  assign match_inc = (k == cand_reg) ? match_reg + 32'd1 : 32'd1;

  for (genvar gi = 0; gi < NUM_PROGS; gi++) begin : g_hit
    assign hit[gi] = (len == half_len(HALF_COUNT, PROG_W'(gi)));
  end

  always_comb begin
    valid = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (hit[i]) begin
        valid = 1'b1;
        k     = PROG_W'(i);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = len;
    match_next   = match_reg;
    cand_next    = cand_reg;
    prog_next    = prog_reg;
    locked_next  = locked_reg;
    changed_next = 1'b0;
    err_next     = 1'b0;
    stalled_next = stalled_reg;
    case (state_reg)
      SEEK: begin
        if (edge_flag) begin
          state_next   = TRACK;
          cnt_next     = '0;
          match_next   = '0;
          stalled_next = 1'b0;
        end
      end
      TRACK, LOCK: begin
        if (edge_flag) begin
          cnt_next     = '0;
          stalled_next = 1'b0;
          if (!valid) begin
            state_next  = TRACK;
            locked_next = 1'b0;
            match_next  = '0;
            err_next    = 1'b1;
          end else if (state_reg == LOCK) begin
            if (k != prog_reg) begin
              state_next  = TRACK;
              locked_next = 1'b0;
              cand_next   = k;
              match_next  = 32'd1;
            end
          end else begin
            cand_next  = k;
            match_next = match_inc;
            if (match_inc >= MATCH_L) begin
              state_next   = LOCK;
              prog_next    = k;
              locked_next  = 1'b1;
              changed_next = 1'b1;
            end
          end
        end else if (len == TIMEOUT_L) begin
          // An edge on this same cycle would have taken the branch above instead.
          state_next   = SEEK;
          locked_next  = 1'b0;
          stalled_next = 1'b1;
          err_next     = 1'b1;
        end
      end
      default: state_next = SEEK;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= SEEK;
      cnt_reg     <= '0;
      match_reg   <= '0;
      cand_reg    <= '0;
      prog_reg    <= '0;
      locked_reg  <= 1'b0;
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
      stalled_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      match_reg   <= match_next;
      cand_reg    <= cand_next;
      prog_reg    <= prog_next;
      locked_reg  <= locked_next;
      changed_reg <= changed_next;
      err_reg     <= err_next;
      stalled_reg <= stalled_next;
    end
  end

  assign prog_out = prog_reg;
  assign locked   = locked_reg;
  assign changed  = changed_reg;
  assign err      = err_reg;
  assign stalled  = stalled_reg;

endmodule

// File: tb/tb_dcm_rate_decoder.sv
// Self-checking bench: table of rate programs, hand-written corner sequences,
// random toggling, all shadowed by a timestamp-based reference model.
module tb_dcm_rate_decoder;

  localparam int HALF = 2;
  localparam int MC   = 2;
  localparam int TMO  = 512;
  localparam int LAT  = 4;  // din toggle to output update, in rising edges

  logic       clock = 1'b0;
  logic       reset;
  logic       din;
  logic [2:0] prog_out;
  logic       locked, changed, err, stalled;

  dcm_rate_decoder #(.HALF_COUNT(HALF), .MATCH_COUNT(MC), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .prog_out (prog_out),
    .locked   (locked),
    .changed  (changed),
    .err      (err),
    .stalled  (stalled)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_tog = 0;
  int q[$];

  // Reference model: half-periods are differences of edge timestamps.
  int   m_mode = 0;  // 0 seeking, 1 tracking, 2 locked
  int   m_last = 0, m_cand = 0, m_match = 0, m_prog = 0;
  logic m_locked = 0, m_changed = 0, m_err = 0, m_stalled = 0;
  int   m_len, m_k;

  function automatic int decode(input int len);
    for (int k = 0; k < 8; k++) if (len == (HALF << k)) return k;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_last = 0; m_cand = 0; m_match = 0; m_prog = 0;
      m_locked = 0; m_changed = 0; m_err = 0; m_stalled = 0;
      q.delete();
    end else begin
      cyc++;
      m_changed = 0;
      m_err = 0;
      if (q.size() > 0 && q[0] == cyc) begin
        void'(q.pop_front());
        if (m_mode == 0) begin
          m_mode = 1; m_last = cyc; m_match = 0; m_stalled = 0;
        end else begin
          m_len = cyc - m_last;
          m_last = cyc;
          m_stalled = 0;
          m_k = decode(m_len);
          if (m_k < 0) begin
            m_err = 1; m_match = 0; m_mode = 1; m_locked = 0;
          end else if (m_mode == 2) begin
            if (m_k != m_prog) begin
              m_mode = 1; m_locked = 0; m_cand = m_k; m_match = 1;
            end
          end else begin
            m_match = (m_k == m_cand) ? m_match + 1 : 1;
            m_cand = m_k;
            if (m_match >= MC) begin
              m_mode = 2; m_prog = m_k; m_locked = 1; m_changed = 1;
            end
          end
        end
      end else if (m_mode != 0 && cyc - m_last >= TMO) begin
        m_mode = 0; m_locked = 0; m_stalled = 1; m_err = 1;
      end
    end
  end

  always @(negedge clock) begin
    checks++;
    if ({prog_out, locked, changed, err, stalled} !==
        {m_prog[2:0], m_locked, m_changed, m_err, m_stalled}) begin
      errors++;
      $display("FAIL model cyc=%0d got prog=%0d lk=%b ch=%b er=%b st=%b want prog=%0d lk=%b ch=%b er=%b st=%b",
               cyc, prog_out, locked, changed, err, stalled,
               m_prog, m_locked, m_changed, m_err, m_stalled);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc=%0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic gen_len(input int len);
    wait_until(last_tog + len);
    din = ~din;
    q.push_back(cyc + LAT);
    last_tog = cyc;
  endtask

  task automatic gen_half(input int k);
    gen_len(HALF << k);
  endtask

  task automatic check_at(input int t);
    wait_until(t);
    @(negedge clock);
  endtask

  typedef struct {
    int         k;
    int         n;
    logic [2:0] prog;
    logic       lk;
    logic       ch;
  } row_t;

  row_t rows[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rows[0] = '{k: 0, n: 3, prog: 3'd0, lk: 1'b1, ch: 1'b1};
    rows[1] = '{k: 3, n: 1, prog: 3'd0, lk: 1'b0, ch: 1'b0};
    rows[2] = '{k: 3, n: 1, prog: 3'd3, lk: 1'b1, ch: 1'b1};
    rows[3] = '{k: 5, n: 2, prog: 3'd5, lk: 1'b1, ch: 1'b1};
    rows[4] = '{k: 2, n: 1, prog: 3'd5, lk: 1'b0, ch: 1'b0};
    rows[5] = '{k: 7, n: 1, prog: 3'd5, lk: 1'b0, ch: 1'b0};
    rows[6] = '{k: 7, n: 1, prog: 3'd7, lk: 1'b1, ch: 1'b1};

    din = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {prog_out, locked, changed, err, stalled}, 0);
    reset = 1'b0;
    last_tog = cyc;

    for (int r = 0; r < 7; r++) begin
      for (int h = 0; h < rows[r].n; h++) gen_half(rows[r].k);
      check_at(last_tog + LAT);
      chk($sformatf("row%0d_locked", r), locked, rows[r].lk);
      chk($sformatf("row%0d_prog", r), prog_out, rows[r].prog);
      chk($sformatf("row%0d_changed", r), changed, rows[r].ch);
      chk($sformatf("row%0d_err", r), err, 0);
      $display("row %0d: k=%0d halves=%0d prog_out=%0d locked=%b", r, rows[r].k, rows[r].n, prog_out, locked);
    end

    // Program 3, then a generator update to program 6 in mid-period.
    gen_half(3); gen_half(3);
    check_at(last_tog + LAT);
    chk("p3_locked", locked, 1); chk("p3_prog", prog_out, 3);
    gen_len(8 + 128);
    check_at(last_tog + LAT);
    chk("odd_err", err, 1); chk("odd_locked", locked, 0); chk("odd_prog", prog_out, 3);
    gen_half(6);
    check_at(last_tog + LAT);
    chk("p6_first_locked", locked, 0);
    gen_half(6);
    check_at(last_tog + LAT);
    chk("p6_locked", locked, 1); chk("p6_prog", prog_out, 6); chk("p6_changed", changed, 1);
    $display("seq odd-period: prog_out=%0d locked=%b", prog_out, locked);

    // Malformed half-period L=5 repeatedly.
    for (int i = 0; i < 6; i++) begin
      gen_len(5);
      check_at(last_tog + LAT);
      chk("l5_err", err, 1); chk("l5_locked", locked, 0); chk("l5_prog", prog_out, 6);
    end
    $display("seq L=5: prog_out=%0d locked=%b", prog_out, locked);

    // Lock on program 7, then freeze din.
    gen_half(7); gen_half(7);
    check_at(last_tog + LAT);
    chk("p7_locked", locked, 1); chk("p7_prog", prog_out, 7);
    check_at(last_tog + LAT + TMO - 1);
    chk("pre_stall_stalled", stalled, 0); chk("pre_stall_locked", locked, 1);
    check_at(last_tog + LAT + TMO);
    chk("stall_stalled", stalled, 1); chk("stall_err", err, 1); chk("stall_locked", locked, 0);
    check_at(last_tog + LAT + TMO + 1);
    chk("stall_err_once", err, 0); chk("stall_hold", stalled, 1);
    gen_len(TMO + 20);
    check_at(last_tog + LAT);
    chk("unstall_stalled", stalled, 0); chk("unstall_err", err, 0); chk("unstall_prog", prog_out, 7);
    $display("seq stall: stalled cleared, prog_out=%0d", prog_out);

    // Edge on exactly the cycle the timeout would fire.
    gen_len(TMO);
    check_at(last_tog + LAT - 1);
    chk("tmo_edge_pre_stalled", stalled, 0);
    check_at(last_tog + LAT);
    chk("tmo_edge_err", err, 1); chk("tmo_edge_stalled", stalled, 0); chk("tmo_edge_locked", locked, 0);
    $display("seq edge-at-timeout: err=%b stalled=%b", err, stalled);

    // Asynchronous reset while locked on program 5.
    gen_half(5); gen_half(5);
    check_at(last_tog + LAT);
    chk("p5_locked", locked, 1); chk("p5_prog", prog_out, 5);
    wait_until(last_tog + 20);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {prog_out, locked, changed, err, stalled}, 0);
    din = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    last_tog = cyc;
    repeat (8) begin
      tick();
      chk("post_reset_quiet", {prog_out, locked, changed, err, stalled}, 0);
    end
    $display("seq async reset: outputs cleared");

    // Random program runs with occasional arbitrary half-periods.
    for (int g = 0; g < 30; g++) begin
      if ($urandom_range(0, 5) == 0) begin
        gen_len(int'($urandom_range(1, 600)));
      end else begin
        int rk, rn;
        rk = int'($urandom_range(0, 7));
        rn = int'($urandom_range(1, 4));
        for (int h = 0; h < rn; h++) gen_half(rk);
      end
    end
    wait_until(last_tog + LAT + 4);
    tick();
    $display("random: done at cyc=%0d prog_out=%0d locked=%b", cyc, prog_out, locked);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
